// File: rtl/load_data_checker.sv
// Packet checker: hunts for the sync word, then validates header, sequence number,
// counting-pattern payload and CRC, and reports per-packet status plus running counters.
module load_data_checker (
    input  logic        clk,
    input  logic        nRST,
    input  logic [15:0] data_in,
    input  logic        data_en,
    input  logic [31:0] packet_head,
    input  logic [15:0] flag_set,
    input  logic [23:0] length_set,
    input  logic [15:0] crc_in,
    output logic        crc_init,
    output logic        crc_en,
    output logic [15:0] crc_out,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        hdr_err,
    output logic        seq_err,
    output logic        data_err,
    output logic        crc_err,
    output logic        tmo_err,
    output logic [31:0] pkt_cnt,
    output logic [31:0] err_cnt,
    output logic [23:0] last_seq
);

    typedef enum logic [3:0] {
        HUNT,
        HEAD1,
        SEQ1,
        SEQ2,
        LEN1,
        LEN2,
        DATA,
        CRCW,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [15:0] seq_hi, seq_hi_n;
    logic [23:0] seq_rx, seq_rx_n;
    logic [7:0]  len_hi, len_hi_n;
    logic [23:0] word_idx, word_idx_n;
    logic [5:0]  idle_cnt, idle_cnt_n;
    logic        hdr_bad, hdr_bad_n;
    logic        hdr_pass, hdr_pass_n;
    logic        f_hdr, f_hdr_n;
    logic        f_seq, f_seq_n;
    logic        f_data, f_data_n;
    logic        f_crc, f_crc_n;
    logic        f_tmo, f_tmo_n;
    logic        any_err_n;
    logic        word_strobe;
    logic        seq_valid;
    logic [23:0] len_minus;
    logic [23:0] num_words;
    logic [15:0] expect_word;
    logic [23:0] seq_expect;

    // Payload length in words: (length_set - 13) >> 1, zero for lengths below 14.
    assign len_minus   = length_set - 24'd13;
    assign num_words   = (length_set < 24'd14) ? 24'd0 : (len_minus >> 1);
    assign expect_word = {word_idx[6:0], 1'b0, word_idx[6:0], 1'b1};
    assign seq_expect  = last_seq + 24'd1;
    assign any_err_n   = f_hdr_n | f_seq_n | f_data_n | f_crc_n | f_tmo_n;
    assign crc_init    = (state == HUNT) || (state == HEAD1) || (state == DONE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= HUNT;
            seq_hi   <= '0;
            seq_rx   <= '0;
            len_hi   <= '0;
            word_idx <= '0;
            idle_cnt <= '0;
            hdr_bad  <= 1'b0;
            hdr_pass <= 1'b0;
            f_hdr    <= 1'b0;
            f_seq    <= 1'b0;
            f_data   <= 1'b0;
            f_crc    <= 1'b0;
            f_tmo    <= 1'b0;
        end else begin
            state    <= state_n;
            seq_hi   <= seq_hi_n;
            seq_rx   <= seq_rx_n;
            len_hi   <= len_hi_n;
            word_idx <= word_idx_n;
            idle_cnt <= idle_cnt_n;
            hdr_bad  <= hdr_bad_n;
            hdr_pass <= hdr_pass_n;
            f_hdr    <= f_hdr_n;
            f_seq    <= f_seq_n;
            f_data   <= f_data_n;
            f_crc    <= f_crc_n;
            f_tmo    <= f_tmo_n;
        end
    end

    always_comb begin
        state_n     = state;
        seq_hi_n    = seq_hi;
        seq_rx_n    = seq_rx;
        len_hi_n    = len_hi;
        word_idx_n  = word_idx;
        idle_cnt_n  = idle_cnt;
        hdr_bad_n   = hdr_bad;
        hdr_pass_n  = hdr_pass;
        f_hdr_n     = f_hdr;
        f_seq_n     = f_seq;
        f_data_n    = f_data;
        f_crc_n     = f_crc;
        f_tmo_n     = f_tmo;
        word_strobe = 1'b0;

        case (state)
            HUNT: begin
                if (data_en && data_in == packet_head[31:16]) begin
                    state_n     = HEAD1;
                    word_strobe = 1'b1;
                end
            end
            HEAD1: begin
                if (data_en) begin
                    if (data_in == packet_head[15:0]) begin
                        state_n     = SEQ1;
                        word_strobe = 1'b1;
                    end else if (data_in == packet_head[31:16]) begin
                        word_strobe = 1'b1;
                    end else begin
                        state_n = HUNT;
                    end
                end
            end
            SEQ1: begin
                if (data_en) begin
                    seq_hi_n    = data_in;
                    state_n     = SEQ2;
                    word_strobe = 1'b1;
                end
            end
            SEQ2: begin
                if (data_en) begin
                    seq_rx_n    = {seq_hi, data_in[15:8]};
                    word_strobe = 1'b1;
                    state_n     = LEN1;
                    if (data_in[7:0] != flag_set[15:8])
                        hdr_bad_n = 1'b1;
                    // The first packet after reset only seeds the expectation.
                    if (seq_valid && {seq_hi, data_in[15:8]} != seq_expect)
                        f_seq_n = 1'b1;
                end
            end
            LEN1: begin
                if (data_en) begin
                    len_hi_n    = data_in[7:0];
                    word_strobe = 1'b1;
                    state_n     = LEN2;
                    if (data_in[15:8] != flag_set[7:0])
                        hdr_bad_n = 1'b1;
                end
            end
            LEN2: begin
                if (data_en) begin
                    word_strobe = 1'b1;
                    word_idx_n  = '0;
                    if (hdr_bad || {len_hi, data_in} != length_set) begin
                        f_hdr_n = 1'b1;
                        state_n = DONE;
                    end else begin
                        hdr_pass_n = 1'b1;
                        state_n    = (num_words == 24'd0) ? CRCW : DATA;
                    end
                end
            end
            DATA: begin
                if (data_en) begin
                    word_strobe = 1'b1;
                    if (data_in != expect_word)
                        f_data_n = 1'b1;
                    if (word_idx == num_words - 24'd1)
                        state_n = CRCW;
                    else
                        word_idx_n = word_idx + 24'd1;
                end
            end
            CRCW: begin
                if (data_en) begin
                    if (data_in != crc_in)
                        f_crc_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n    = HUNT;
                hdr_bad_n  = 1'b0;
                hdr_pass_n = 1'b0;
                f_hdr_n    = 1'b0;
                f_seq_n    = 1'b0;
                f_data_n   = 1'b0;
                f_crc_n    = 1'b0;
                f_tmo_n    = 1'b0;
            end
            default: state_n = HUNT;
        endcase

        // Inactivity watchdog: the 64th consecutive idle clock inside a packet aborts it.
        if (state == HUNT || state == DONE) begin
            idle_cnt_n = '0;
        end else if (data_en) begin
            idle_cnt_n = '0;
        end else if (idle_cnt == 6'd63) begin
            idle_cnt_n = '0;
            f_tmo_n    = 1'b1;
            state_n    = DONE;
        end else begin
            idle_cnt_n = idle_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            crc_en  <= 1'b0;
            crc_out <= '0;
        end else begin
            crc_en <= word_strobe;
            if (word_strobe)
                crc_out <= data_in;
        end
    end

    // Status is captured on entry to DONE so it is valid with pkt_done and held afterwards.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            hdr_err   <= 1'b0;
            seq_err   <= 1'b0;
            data_err  <= 1'b0;
            crc_err   <= 1'b0;
            tmo_err   <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            last_seq  <= '0;
            seq_valid <= 1'b0;
        end else if (state_n == DONE) begin
            pkt_done <= 1'b1;
            pkt_ok   <= ~any_err_n;
            hdr_err  <= f_hdr_n;
            seq_err  <= f_seq_n;
            data_err <= f_data_n;
            crc_err  <= f_crc_n;
            tmo_err  <= f_tmo_n;
            if (any_err_n)
                err_cnt <= err_cnt + 32'd1;
            else
                pkt_cnt <= pkt_cnt + 32'd1;
            if (hdr_pass_n) begin
                last_seq  <= seq_rx_n;
                seq_valid <= 1'b1;
            end
        end else begin
            pkt_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_data_checker.sv
// Directed bench for load_data_checker: a table of whole-packet vectors plus
// hand sequences for resync, idle gaps, timeout and reset mid-packet.
module tb_load_data_checker;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_en = 1'b0;
    logic [31:0] packet_head = 32'h5716EB90;
    logic [15:0] flag_set = 16'h00FF;
    logic [23:0] length_set = 24'h000020;
    logic [15:0] crc_in = '0;
    logic        crc_init, crc_en, pkt_done;
    logic [15:0] crc_out;
    logic        pkt_ok, hdr_err, seq_err, data_err, crc_err, tmo_err;
    logic [31:0] pkt_cnt, err_cnt;
    logic [23:0] last_seq;

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    logic        cap_ok, cap_hdr, cap_seq, cap_data, cap_crc, cap_tmo;
    logic [15:0] cap_crc_out;

    logic [15:0] pkt_q[$];
    int          crc_pos;

    typedef struct {
        bit          rst;
        logic [23:0] seq;
        logic [15:0] flag;
        logic [23:0] len_set;
        logic [23:0] len_field;
        int          corrupt;
        bit          crc_good;
        bit          e_ok, e_hdr, e_seq, e_data, e_crc;
        logic [31:0] e_pkt, e_err;
        logic [23:0] e_last;
    } vec_t;

    vec_t vecs[16];

    load_data_checker dut (
        .clk(clk), .nRST(nRST), .data_in(data_in), .data_en(data_en),
        .packet_head(packet_head), .flag_set(flag_set), .length_set(length_set),
        .crc_in(crc_in), .crc_init(crc_init), .crc_en(crc_en), .crc_out(crc_out),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .hdr_err(hdr_err), .seq_err(seq_err),
        .data_err(data_err), .crc_err(crc_err), .tmo_err(tmo_err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .last_seq(last_seq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_done) begin
            done_cnt++;
            cap_ok   = pkt_ok;
            cap_hdr  = hdr_err;
            cap_seq  = seq_err;
            cap_data = data_err;
            cap_crc  = crc_err;
            cap_tmo  = tmo_err;
        end
        if (crc_en) begin
            strobe_cnt++;
            cap_crc_out = crc_out;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int n_words(input logic [23:0] len);
        if (len < 24'd14) return 0;
        return int'((len - 24'd13) >> 1);
    endfunction

    task automatic send_word(input logic [15:0] w);
        @(negedge clk);
        data_in = w;
        data_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b0;
        data_en = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task automatic build(input logic [23:0] seq, input logic [15:0] flag, input logic [23:0] lenf,
                         input int n, input int corrupt, input logic [15:0] crcw, input bit hdr_only);
        logic [15:0] w;
        pkt_q.delete();
        pkt_q.push_back(packet_head[31:16]);
        pkt_q.push_back(packet_head[15:0]);
        pkt_q.push_back(seq[23:8]);
        pkt_q.push_back({seq[7:0], flag[15:8]});
        pkt_q.push_back({flag[7:0], lenf[23:16]});
        pkt_q.push_back(lenf[15:0]);
        if (!hdr_only) begin
            for (int k = 0; k < n; k++) begin
                w = {8'(2 * k), 8'(2 * k + 1)};
                if (k == corrupt) w = 16'h0000;
                pkt_q.push_back(w);
            end
            crc_pos = pkt_q.size();
            pkt_q.push_back(crcw);
        end else begin
            crc_pos = pkt_q.size();
        end
    endtask

    task automatic send_q(input int gap);
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (i == crc_pos) idle(3);
            send_word(pkt_q[i]);
            if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    task automatic wait_done(input string name, input int start);
        int c = 0;
        while (done_cnt == start && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput(name, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int          n, d0, s0;
        bit          hdr_only;
        logic [15:0] crcv, last_w;
        if (v.rst) do_reset();
        length_set = v.len_set;
        n        = n_words(v.len_set);
        hdr_only = v.e_hdr;
        crcv     = {v.seq[7:0], 8'h5A};
        crc_in   = crcv;
        build(v.seq, v.flag, v.len_field, n, v.corrupt, v.crc_good ? crcv : (crcv ^ 16'h0F0F), hdr_only);
        last_w = pkt_q[crc_pos - 1];
        d0 = done_cnt;
        s0 = strobe_cnt;
        send_q(0);
        wait_done($sformatf("v%0d pkt_done", idx), d0);
        idle(2);
        checkOutput($sformatf("v%0d pkt_ok", idx), 32'(cap_ok), 32'(v.e_ok));
        checkOutput($sformatf("v%0d hdr_err", idx), 32'(cap_hdr), 32'(v.e_hdr));
        checkOutput($sformatf("v%0d seq_err", idx), 32'(cap_seq), 32'(v.e_seq));
        checkOutput($sformatf("v%0d data_err", idx), 32'(cap_data), 32'(v.e_data));
        checkOutput($sformatf("v%0d crc_err", idx), 32'(cap_crc), 32'(v.e_crc));
        checkOutput($sformatf("v%0d tmo_err", idx), 32'(cap_tmo), 32'd0);
        checkOutput($sformatf("v%0d pkt_ok held", idx), 32'(pkt_ok), 32'(v.e_ok));
        checkOutput($sformatf("v%0d pkt_cnt", idx), pkt_cnt, v.e_pkt);
        checkOutput($sformatf("v%0d err_cnt", idx), err_cnt, v.e_err);
        checkOutput($sformatf("v%0d last_seq", idx), 32'(last_seq), 32'(v.e_last));
        checkOutput($sformatf("v%0d crc strobes", idx), 32'(strobe_cnt - s0), 32'(hdr_only ? 6 : 6 + n));
        checkOutput($sformatf("v%0d last crc_out", idx), 32'(cap_crc_out), 32'(last_w));
    endtask

    initial begin
        int d0;
        //         rst   seq          flag      len_set    len_field  cor crc  ok hdr seq dat crc  pkt    err    last
        vecs[0]  = '{1'b1, 24'h000000, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 24'h000000};
        vecs[1]  = '{1'b0, 24'h000001, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0, 24'h000001};
        vecs[2]  = '{1'b1, 24'h000005, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 24'h000005};
        vecs[3]  = '{1'b0, 24'h000007, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1, 24'h000007};
        vecs[4]  = '{1'b0, 24'h000008, 16'h00FF, 24'h20, 24'h20,  3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 32'd2, 24'h000008};
        vecs[5]  = '{1'b0, 24'h000009, 16'h00FF, 24'h20, 24'h21, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd3, 24'h000008};
        vecs[6]  = '{1'b0, 24'h000009, 16'h01FF, 24'h20, 24'h20, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd4, 24'h000008};
        vecs[7]  = '{1'b0, 24'h000009, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd4, 24'h000009};
        vecs[8]  = '{1'b0, 24'h00000A, 16'h00FF, 24'h20, 24'h20,  8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 32'd5, 24'h00000A};
        vecs[9]  = '{1'b0, 24'h00000B, 16'h00FF, 24'h20, 24'h20, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd6, 24'h00000B};
        vecs[10] = '{1'b0, 24'h00000C, 16'h00FF, 24'h0A, 24'h0A, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd6, 24'h00000C};
        vecs[11] = '{1'b0, 24'h00000D, 16'h00FF, 24'h0F, 24'h0F, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'd6, 24'h00000D};
        vecs[12] = '{1'b0, 24'h00000E, 16'h00FF, 24'h0F, 24'h0F,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4, 32'd7, 24'h00000E};
        vecs[13] = '{1'b1, 24'hFFFFFF, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 24'hFFFFFF};
        vecs[14] = '{1'b0, 24'h000000, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd0, 24'h000000};
        vecs[15] = '{1'b0, 24'h000002, 16'h00FF, 24'h20, 24'h20, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd1, 24'h000002};

        repeat (2) @(negedge clk);
        checkOutput("reset crc_init", 32'(crc_init), 32'd1);
        checkOutput("reset crc_en", 32'(crc_en), 32'd0);
        checkOutput("reset crc_out", 32'(crc_out), 32'd0);
        checkOutput("reset pkt_done", 32'(pkt_done), 32'd0);
        checkOutput("reset pkt_ok", 32'(pkt_ok), 32'd0);
        checkOutput("reset pkt_cnt", pkt_cnt, 32'd0);
        checkOutput("reset err_cnt", err_cnt, 32'd0);
        checkOutput("reset last_seq", 32'(last_seq), 32'd0);
        nRST = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);

        // Broken sync pair, then a packet that starts with a repeated W0.
        length_set = 24'h20;
        d0 = done_cnt;
        send_word(16'h5716);
        idle(1);
        checkOutput("resync crc_en after W0", 32'(crc_en), 32'd1);
        checkOutput("resync crc_out after W0", 32'(crc_out), 32'h5716);
        checkOutput("resync crc_init in HEAD1", 32'(crc_init), 32'd1);
        send_word(16'h1234);
        idle(1);
        checkOutput("resync crc_en after junk", 32'(crc_en), 32'd0);
        idle(3);
        checkOutput("resync no pkt_done", 32'(done_cnt - d0), 32'd0);
        crc_in = 16'hBEEF;
        build(24'h000003, 16'h00FF, 24'h20, 9, -1, 16'hBEEF, 1'b0);
        pkt_q.push_front(16'h5716);
        crc_pos++;
        d0 = done_cnt;
        send_q(0);
        wait_done("resync pkt_done", d0);
        checkOutput("resync pkt_ok", 32'(cap_ok), 32'd1);
        checkOutput("resync pkt_cnt", pkt_cnt, 32'd3);
        checkOutput("resync last_seq", 32'(last_seq), 32'd3);

        // Idle cycles between every word.
        build(24'h000004, 16'h00FF, 24'h20, 9, -1, 16'hBEEF, 1'b0);
        d0 = done_cnt;
        send_q(2);
        wait_done("gap pkt_done", d0);
        checkOutput("gap pkt_ok", 32'(cap_ok), 32'd1);
        checkOutput("gap pkt_cnt", pkt_cnt, 32'd4);

        // Stall after W4: 63 idle clocks are tolerated, the 64th aborts.
        build(24'h000005, 16'h00FF, 24'h20, 9, -1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) send_word(pkt_q[i]);
        idle(64);
        checkOutput("tmo after 63 idle", 32'(pkt_done), 32'd0);
        @(negedge clk);
        checkOutput("tmo after 64 idle", 32'(pkt_done), 32'd1);
        checkOutput("tmo tmo_err", 32'(tmo_err), 32'd1);
        checkOutput("tmo pkt_ok", 32'(pkt_ok), 32'd0);
        checkOutput("tmo hdr_err", 32'(hdr_err), 32'd0);
        idle(2);
        checkOutput("tmo err_cnt", err_cnt, 32'd2);
        checkOutput("tmo last_seq kept", 32'(last_seq), 32'd4);
        send_q(0);
        idle(3);
        checkOutput("post-tmo pkt_cnt", pkt_cnt, 32'd5);
        checkOutput("post-tmo last_seq", 32'(last_seq), 32'd5);

        // Reset in the middle of a packet.
        build(24'h000006, 16'h00FF, 24'h20, 9, -1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 4; i++) send_word(pkt_q[i]);
        idle(1);
        checkOutput("midpkt crc_init low", 32'(crc_init), 32'd0);
        d0 = done_cnt;
        nRST = 1'b0;
        #1;
        checkOutput("midpkt rst crc_init", 32'(crc_init), 32'd1);
        checkOutput("midpkt rst pkt_cnt", pkt_cnt, 32'd0);
        checkOutput("midpkt rst last_seq", 32'(last_seq), 32'd0);
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        idle(3);
        checkOutput("midpkt no pkt_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("midpkt err_cnt", err_cnt, 32'd0);
        build(24'h000123, 16'h00FF, 24'h20, 9, -1, 16'hBEEF, 1'b0);
        d0 = done_cnt;
        send_q(0);
        wait_done("midpkt next pkt_done", d0);
        checkOutput("midpkt next pkt_ok", 32'(cap_ok), 32'd1);
        checkOutput("midpkt next seq_err", 32'(cap_seq), 32'd0);
        checkOutput("midpkt next pkt_cnt", pkt_cnt, 32'd1);
        checkOutput("midpkt next last_seq", 32'(last_seq), 32'h000123);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/load_data_checker.md
LOAD_DATA_CHECKER -- requirements
Module: load_data_checker

Interface
REQ-001 SHALL have ports: clk  in  1  clock; nRST  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have data_in  in  16  descrambled packet word; data_en  in  1  word valid.
REQ-003 SHALL have packet_head  in  32  sync word; flag_set  in  16  expected flag; length_set  in  24  expected length field.
REQ-004 SHALL have crc_in  in  16  external CRC engine result; crc_init  out  1  engine clear; crc_en  out  1  engine word strobe; crc_out  out  16  engine word.
REQ-005 SHALL have pkt_done  out  1  one-cycle end-of-packet pulse; pkt_ok, hdr_err, seq_err, data_err, crc_err, tmo_err  out  1 each  status, valid when pkt_done=1.
REQ-006 SHALL have pkt_cnt  out  32  good packets; err_cnt  out  32  bad packets; last_seq  out  24  last received sequence number.

Function
REQ-007 Packet word order SHALL be: W0 head[31:16], W1 head[15:0], W2 seq[23:8], W3 {seq[7:0],flag[15:8]}, W4 {flag[7:0],len[23:16]}, W5 len[15:0], then N data words, then one CRC word.
REQ-008 N SHALL be (length_set-14+1)>>1 computed in 24 bits; length_set<14 SHALL give N=0.
REQ-009 Data word k (k=0..N-1) SHALL equal {(2k)[7:0], (2k+1)[7:0]}, wrapping mod 256 per byte.
REQ-010 Words SHALL be consumed only on cycles with data_en=1; idle cycles between words SHALL be allowed in every state.
REQ-011 States: HUNT, HEAD1, SEQ1, SEQ2, LEN1, LEN2, DATA, CRCW, DONE.
REQ-012 HUNT: word==head[31:16] -> HEAD1; else stay.
REQ-013 HEAD1: word==head[15:0] -> SEQ1; word==head[31:16] -> stay HEAD1; else -> HUNT, no pkt_done.
REQ-014 SEQ1 -> SEQ2 -> LEN1 -> LEN2, one word each; SEQ2 low byte and LEN1 high byte SHALL be compared with flag_set.
REQ-015 In LEN2, received length SHALL be compared with length_set; any flag or length mismatch SHALL set hdr_err and go to DONE immediately.
REQ-016 In LEN2 with no mismatch: N=0 -> CRCW, else -> DATA.
REQ-017 DATA: each word is compared against REQ-009; a mismatch SHALL set data_err (sticky for the packet); after word N-1 -> CRCW.
REQ-018 CRCW: the next valid word SHALL be compared with crc_in; a mismatch sets crc_err; then -> DONE.
REQ-019 The transmitter guarantees a gap of at least 3 clocks between the last data word and the CRC word; crc_in SHALL be stable by then.
REQ-020 crc_out/crc_en SHALL register every accepted word W0..W(5+N), excluding the CRC word, one cycle after acceptance.
REQ-021 crc_init SHALL be 1 in HUNT, HEAD1 until W1 matches, and DONE; otherwise 0.
REQ-022 Sequence: the first packet after reset SHALL load the expectation without error. Thereafter expected = last_seq+1 mod 2^24; a mismatch sets seq_err. last_seq SHALL update at DONE whenever the header passed.
REQ-023 Timeout: in any state other than HUNT/DONE, 64 consecutive clocks with data_en=0 SHALL set tmo_err and go to DONE.
REQ-024 DONE (one cycle): pkt_done=1; pkt_ok=1 iff no error flag is set; pkt_cnt+1 if ok, else err_cnt+1; both counters wrap at 2^32; all flags clear; -> HUNT.
REQ-025 Status outputs SHALL hold their values until the next pkt_done.

Reset
REQ-026 On nRST=0, state SHALL go to HUNT and all outputs SHALL be 0 except crc_init=1; the sequence-expectation valid bit SHALL clear.
REQ-027 Reset mid-packet SHALL discard the packet without pkt_done and without any counter change.

Verification
REQ-028 head=5716EB90, flag=00FF, length=000020: send a correct packet with seq 0 and a correct CRC -> pkt_done, pkt_ok=1, pkt_cnt=1, last_seq=0.
REQ-029 Send packets with seq 5 then 7 -> second packet: seq_err=1, err_cnt=1, last_seq=7.
REQ-030 Corrupt data word 3 to 0x0000 -> data_err=1, crc_err=1, pkt_ok=0.
REQ-031 Send W0 then 0x1234 -> return to HUNT, no pkt_done; send W0,W0,W1,... -> packet accepted.
REQ-032 Stop after W4 for 64 idle clocks -> tmo_err=1, err_cnt+1.
REQ-033 length field 0x000021 with length_set=0x000020 -> hdr_err=1 at W5, no data words consumed.
